dlatch_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one WIDTH-bit D-latch register (d/en/reset datapath)

---
 rtl/dlatch_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_dlatch_rr_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlatch_rr_scheduler.sv
// Round-robin scheduler sharing one D-latch register among N_REQ requesters.
// It picks a requester, presents its data with a timed latch_en window, and
// inserts a settle gap before the next operation. It also sequences latch
// clears, and a clear takes priority over pending writes.
//
// Handshake: requester i raises req[i] with stable req_d slice i and holds it
// until ack[i] pulses for one cycle. The data is captured at grant time, so
// later changes to req_d or req during the write are ignored. A req still high
// after its ack counts as a new request.
module dlatch_rr_scheduler #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 1,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_d,
  input  logic                   clr_req,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       latch_d,
  output logic                   latch_en,
  output logic                   latch_clr,
  output logic                   busy,
  output logic [IDW-1:0]         last_id,
  output logic [1:0]             state_dbg
);

  localparam int CNT_MAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_GAP, S_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [WIDTH-1:0] latch_d_q, latch_d_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             latch_en_q, latch_en_d;
  logic             latch_clr_q, latch_clr_d;
  logic             busy_q, busy_d;

  logic [IDW-1:0]   pick;
  logic             found;

  // Round-robin pick: the first asserted request at or after the pointer, wrapping.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    last_id_d   = last_id_q;
    latch_d_d   = latch_d_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    latch_en_d  = latch_en_q;
    latch_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        latch_en_d = 1'b0;
        gnt_d      = '0;
        if (clr_req) begin
          state_d     = S_CLEAR;
          latch_clr_d = 1'b1;
          latch_d_d   = '0;
        end else if (found) begin
          state_d     = S_OPEN;
          cnt_d       = '0;
          sel_d       = pick;
          latch_d_d   = req_d[int'(pick)*WIDTH +: WIDTH];
          gnt_d[pick] = 1'b1;
          latch_en_d  = 1'b1;
        end
      end
      S_OPEN: begin
        if (cnt_q == CW'(EN_CYCLES - 1)) begin
          state_d      = S_GAP;
          cnt_d        = '0;
          latch_en_d   = 1'b0;
          gnt_d        = '0;
          ack_d[sel_q] = 1'b1;
          last_id_d    = sel_q;
          ptr_d        = (sel_q == IDW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight write without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      last_id_q   <= '0;
      latch_d_q   <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      latch_en_q  <= 1'b0;
      latch_clr_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      last_id_q   <= last_id_d;
      latch_d_q   <= latch_d_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      latch_en_q  <= latch_en_d;
      latch_clr_q <= latch_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign latch_d   = latch_d_q;
  assign latch_en  = latch_en_q;
  assign latch_clr = latch_clr_q;
  assign busy      = busy_q;
  assign last_id   = last_id_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dlatch_rr_scheduler.sv
// Bench for dlatch_rr_scheduler. Each completed operation (ack or latch_clr)
// is matched against an expected queue that the scenario tasks fill.
module tb_dlatch_rr_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int EW  = 1 + IDW + W;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_d = '0;
  logic           clr_req = 1'b0;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   latch_d;
  logic           latch_en, latch_clr, busy;
  logic [IDW-1:0] last_id;
  logic [1:0]     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  dlatch_rr_scheduler #(.N_REQ(N), .WIDTH(W), .EN_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_d(req_d), .clr_req(clr_req),
    .gnt(gnt), .ack(ack), .latch_d(latch_d), .latch_en(latch_en),
    .latch_clr(latch_clr), .busy(busy), .last_id(last_id), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard and invariant monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0]  obs, e;
    logic [IDW-1:0] obs_id;
    if (!reset) begin
      checks++;
      if ($countones(gnt) > 1 || $countones(ack) > 1 || (latch_en && latch_clr)) begin
        errors++;
        $display("FAIL invariant: gnt=%b ack=%b latch_en=%b latch_clr=%b", gnt, ack, latch_en, latch_clr);
      end
      if (ack != '0 || latch_clr) begin
        obs_id = '0;
        for (int i = 0; i < N; i++) if (ack[i]) obs_id = IDW'(i);
        obs = {latch_clr, obs_id, latch_d};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got %h, expected nothing", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL scoreboard_op: got %h, expected %h", obs, e);
          end
        end
      end
    end
  end

  // Driver helpers
  task automatic push_wr(input int id, input logic [W-1:0] d);
    exp_q.push_back({1'b0, IDW'(id), d});
  endtask

  task automatic push_clr();
    exp_q.push_back({1'b1, {IDW{1'b0}}, {W{1'b0}}});
  endtask

  task automatic set_data(input int id, input logic [W-1:0] d);
    req_d[id*W +: W] = d;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (ack != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (gnt != '0) ok = 1'b1;
    end
  endtask

  // 1: reset state, then reset in the middle of a write
  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, ack, latch_d, latch_en, latch_clr, busy, last_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b ack=%b d=%h en=%b clr=%b busy=%b id=%0d, expected all 0",
               gnt, ack, latch_d, latch_en, latch_clr, busy, last_id);
    end
    reset = 1'b0;
    req = 4'b0010; set_data(1, 8'h77);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || latch_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_open: got gnt=%b en=%b, expected 0010 1", gnt, latch_en);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, ack, latch_d, latch_en, latch_clr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: got gnt=%b ack=%b d=%h en=%b clr=%b busy=%b, expected all 0",
               gnt, ack, latch_d, latch_en, latch_clr, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0011; set_data(0, 8'h12);
    push_wr(0, 8'h12); push_wr(1, 8'h77);
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got ack=%b ok=%0d, expected 0001", ack, ok);
    end
    req = 4'b0010;
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0010) begin
      errors++;
      $display("FAIL reset_second_grant: got ack=%b ok=%0d, expected 0010", ack, ok);
    end
    req = '0;
    wait_idle(ok);
  endtask

  // 2: single write with exact timing
  task automatic test_single_write();
    bit ok;
    req = 4'b0100; set_data(2, 8'hA5); push_wr(2, 8'hA5);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || latch_d !== 8'hA5 || latch_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_open1: got gnt=%b d=%h en=%b busy=%b, expected 0100 a5 1 1", gnt, latch_d, latch_en, busy);
    end
    @(negedge clk);
    checks++;
    if (latch_en !== 1'b1 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_open2: got en=%b ack=%b, expected 1 0000", latch_en, ack);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0100 || latch_en !== 1'b0 || gnt !== 4'b0000 || last_id !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: got ack=%b en=%b gnt=%b id=%0d busy=%b, expected 0100 0 0000 2 1",
               ack, latch_en, gnt, last_id, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got busy=%b ack=%b, expected 0 0000", busy, ack);
    end
  endtask

  // 4: wrap from pointer 3 to requester 0
  task automatic test_wrap();
    bit ok;
    req = 4'b1001; set_data(3, 8'h33); set_data(0, 8'h90);
    push_wr(3, 8'h33); push_wr(0, 8'h90);
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: got ack=%b ok=%0d, expected 1000", ack, ok);
    end
    req = 4'b0001;
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_second: got ack=%b ok=%0d, expected 0001", ack, ok);
    end
    req = '0;
    wait_idle(ok);
  endtask

  // 3: fairness with all requests held
  task automatic test_fairness();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] dv[4];
    req = 4'b1000; set_data(3, 8'hC3); push_wr(3, 8'hC3);
    wait_ack(ok);
    req = '0;
    wait_idle(ok);
    for (int i = 0; i < N; i++) begin
      dv[i] = W'($urandom_range(0, 255));
      set_data(i, dv[i]);
    end
    for (int i = 0; i < 5; i++) push_wr(order[i], dv[order[i]]);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ok);
      checks++;
      if (!ok || ack !== (4'b0001 << order[i])) begin
        errors++;
        $display("FAIL fairness_%0d: got ack=%b ok=%0d, expected %b", i, ack, ok, 4'b0001 << order[i]);
      end
    end
    req = '0;
    wait_idle(ok);
  endtask

  // 5: clear beats a pending write; clear raised during OPEN follows the write
  task automatic test_clear_priority();
    bit ok;
    clr_req = 1'b1; req = 4'b0001; set_data(0, 8'h3C);
    push_clr(); push_wr(0, 8'h3C);
    @(negedge clk);
    checks++;
    if (latch_clr !== 1'b1 || latch_d !== 8'h00 || latch_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse: got clr=%b d=%h en=%b gnt=%b busy=%b, expected 1 00 0 0000 1",
               latch_clr, latch_d, latch_en, gnt, busy);
    end
    clr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (latch_clr !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL clear_one_cycle: got clr=%b ack=%b, expected 0 0000", latch_clr, ack);
    end
    wait_gnt(ok);
    clr_req = 1'b1; push_clr();
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0001 || latch_d !== 8'h3C) begin
      errors++;
      $display("FAIL clear_then_write: got ack=%b d=%h ok=%0d, expected 0001 3c", ack, latch_d, ok);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (latch_clr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_pending_idle: got clr=%b busy=%b, expected 0 0", latch_clr, busy);
    end
    @(negedge clk);
    checks++;
    if (latch_clr !== 1'b1 || latch_d !== 8'h00) begin
      errors++;
      $display("FAIL clear_serviced: got clr=%b d=%h, expected 1 00", latch_clr, latch_d);
    end
    clr_req = 1'b0;
    wait_idle(ok);
  endtask

  // 6: data captured at grant survives req_d change and req drop
  task automatic test_data_hold();
    bit ok;
    req = 4'b0010; set_data(1, 8'h5A); push_wr(1, 8'h5A);
    @(negedge clk);
    set_data(1, 8'hFF); req = '0;
    @(negedge clk);
    checks++;
    if (latch_d !== 8'h5A || latch_en !== 1'b1 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL hold_open: got d=%h en=%b gnt=%b, expected 5a 1 0010", latch_d, latch_en, gnt);
    end
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0010 || last_id !== 2'd1) begin
      errors++;
      $display("FAIL hold_ack: got ack=%b id=%0d ok=%0d, expected 0010 1", ack, last_id, ok);
    end
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrap();
    test_fairness();
    test_clear_priority();
    test_data_hold();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
